// File: rtl/pkt_flow_priorer.sv
// pkt_flow_priorer: flow-history packet prioritiser.
// Packets enter a small FIFO. Each FIFO head is looked up in a fully-associative
// flow table. A new flow gets the highest priority. The priority of a flow falls
// by one level every 2^LEVEL_SHIFT packets of that flow.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready input handshake; carries in_key (flow key) and in_data
//   out_valid/out_ready output handshake; carries out_data, out_prio,
//                     out_flow_idx and out_new_flow
//   flow_occupancy    registered count of valid table entries
// Optional macro PKT_FLOW_PRIORER_AGING_EN: every AGE_PERIOD cycles, all flow
// counters are halved, and an entry whose counter decays to zero is freed.
module pkt_flow_priorer #(
    parameter int DWIDTH      = 32,
    parameter int KEY_WIDTH   = 104,
    parameter int NUM_FLOWS   = 16,
    parameter int IN_DEPTH    = 8,
    parameter int NUM_PRIO    = 8,
    parameter int CNT_WIDTH   = 16,
    parameter int LEVEL_SHIFT = 2,
    parameter int AGE_PERIOD  = 1024
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [KEY_WIDTH-1:0]         in_key,
    input  logic [DWIDTH-1:0]            in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DWIDTH-1:0]            out_data,
    output logic [$clog2(NUM_PRIO)-1:0]  out_prio,
    output logic [$clog2(NUM_FLOWS)-1:0] out_flow_idx,
    output logic                         out_new_flow,
    output logic [$clog2(NUM_FLOWS):0]   flow_occupancy
);
    localparam int AW  = $clog2(IN_DEPTH);
    localparam int FIW = $clog2(NUM_FLOWS);
    localparam int PW  = $clog2(NUM_PRIO);

    // input FIFO; the pointers are one bit wider than the address so that full can be told apart from empty
    logic [KEY_WIDTH-1:0] r_fkey  [IN_DEPTH];
    logic [DWIDTH-1:0]    r_fdata [IN_DEPTH];
    logic [AW:0]          r_wptr, r_rptr;

    // flow table
    logic [NUM_FLOWS-1:0] r_vld;
    logic [KEY_WIDTH-1:0] r_key [NUM_FLOWS];
    logic [CNT_WIDTH-1:0] r_cnt [NUM_FLOWS];
    logic [FIW-1:0]       r_rr_ptr;
    logic [FIW:0]         r_occ;

    logic                 r_out_valid;
    logic [DWIDTH-1:0]    r_out_data;
    logic [PW-1:0]        r_out_prio;
    logic [FIW-1:0]       r_out_idx;
    logic                 r_out_new;

    logic                 w_full, w_empty, w_push, w_fire, w_tick;
    logic [KEY_WIDTH-1:0] w_head_key;
    logic [DWIDTH-1:0]    w_head_data;
    logic                 w_hit, w_free;
    logic [FIW-1:0]       w_hit_idx, w_free_idx, w_tgt;
    logic [CNT_WIDTH-1:0] w_c_raw, w_c, w_cnt_inc, w_level;
    logic [PW-1:0]        w_prio;
    logic [NUM_FLOWS-1:0] w_vld_nxt;
    logic [FIW:0]         w_occ_nxt;

    assign w_full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_empty     = (r_wptr == r_rptr);
    assign in_ready    = !w_full;
    assign w_push      = in_valid && !w_full;
    assign w_fire      = !w_empty && (!r_out_valid || out_ready);
    assign w_head_key  = r_fkey[r_rptr[AW-1:0]];
    assign w_head_data = r_fdata[r_rptr[AW-1:0]];

`ifdef PKT_FLOW_PRIORER_AGING_EN
    localparam int TW = (AGE_PERIOD > 1) ? $clog2(AGE_PERIOD) : 1;
    logic [TW-1:0] r_age;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_age <= '0;
        else if (r_age == TW'(AGE_PERIOD - 1))
            r_age <= '0;
        else
            r_age <= r_age + 1'b1;
    end

    assign w_tick = (r_age == TW'(AGE_PERIOD - 1));
`else
    logic w_unused_age;
    assign w_unused_age = (AGE_PERIOD != 0);
    assign w_tick       = 1'b0;
`endif

    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_free     = 1'b0;
        w_free_idx = '0;
        for (int i = 0; i < NUM_FLOWS; i++) begin
            if (r_vld[i] && r_key[i] == w_head_key) begin
                w_hit     = 1'b1;
                w_hit_idx = FIW'(i);
            end
        end
        // The loop runs downward, so the last match it records is the lowest free index.
        for (int i = NUM_FLOWS - 1; i >= 0; i--) begin
            if (!r_vld[i]) begin
                w_free     = 1'b1;
                w_free_idx = FIW'(i);
            end
        end
    end

    assign w_tgt     = w_hit ? w_hit_idx : (w_free ? w_free_idx : r_rr_ptr);
    assign w_c_raw   = r_cnt[w_hit_idx];
    // When an aging tick lands in the same cycle as a hit, the halving is applied first.
    assign w_c       = w_hit ? (w_tick ? (w_c_raw >> 1) : w_c_raw) : '0;
    assign w_cnt_inc = (&w_c) ? w_c : w_c + 1'b1;
    assign w_level   = w_c >> LEVEL_SHIFT;
    assign w_prio    = (w_level >= CNT_WIDTH'(NUM_PRIO - 1)) ? '0
                                                              : PW'(NUM_PRIO - 1) - PW'(w_level);

    always_comb begin
        w_vld_nxt = r_vld;
        w_occ_nxt = '0;
        for (int i = 0; i < NUM_FLOWS; i++) begin
            if (w_tick && (r_cnt[i] >> 1) == '0)
                w_vld_nxt[i] = 1'b0;
            if (w_fire && w_tgt == FIW'(i))
                w_vld_nxt[i] = 1'b1;
            w_occ_nxt = w_occ_nxt + {{FIW{1'b0}}, w_vld_nxt[i]};
        end
    end

    // Storage arrays have no reset; their contents are only read under the valid bits and pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fkey[r_wptr[AW-1:0]]  <= in_key;
            r_fdata[r_wptr[AW-1:0]] <= in_data;
        end
        if (w_fire && !w_hit)
            r_key[w_tgt] <= w_head_key;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_vld       <= '0;
            r_rr_ptr    <= '0;
            r_occ       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_prio  <= '0;
            r_out_idx   <= '0;
            r_out_new   <= 1'b0;
            for (int i = 0; i < NUM_FLOWS; i++)
                r_cnt[i] <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_fire)
                r_rptr <= r_rptr + 1'b1;
            r_vld <= w_vld_nxt;
            r_occ <= w_occ_nxt;
            for (int i = 0; i < NUM_FLOWS; i++) begin
                if (w_fire && w_tgt == FIW'(i))
                    r_cnt[i] <= w_hit ? w_cnt_inc : CNT_WIDTH'(1);
                else if (w_tick)
                    r_cnt[i] <= r_cnt[i] >> 1;
            end
            if (w_fire && !w_hit && !w_free)
                r_rr_ptr <= (r_rr_ptr == FIW'(NUM_FLOWS - 1)) ? '0 : r_rr_ptr + 1'b1;
            if (w_fire) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_head_data;
                r_out_prio  <= w_prio;
                r_out_idx   <= w_tgt;
                r_out_new   <= !w_hit;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid      = r_out_valid;
    assign out_data       = r_out_data;
    assign out_prio       = r_out_prio;
    assign out_flow_idx   = r_out_idx;
    assign out_new_flow   = r_out_new;
    assign flow_occupancy = r_occ;
endmodule
